fetch_unit: RTL and testbench

Instruction-fetch stage of the SCU ISA pipelined CPU. It owns the program counter and drives the word address into `instruction_memory`, which has one cycle of registered read latency. It pairs each returned instruction word with its PC and a valid flag for the IF/ID boundary. It also handles stall hold, branch/jump redirect with wrong-path squash, and PC wrap-around.

---
 rtl/scu_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/scu_pkg.sv
// Shared SCU ISA constants used by the fetch stage: NOP encoding,
// opcode field position and the word-address width helper.
package scu_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 28;

  typedef logic [OPCODE_MSB-OPCODE_LSB:0] opcode_t;

  function automatic opcode_t opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // Bits needed to index a power-of-two instruction memory (at least 1).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Pipeline-side and memory-side signals of the fetch stage.
// The slave modport is the fetch_unit view; master is the environment view.
interface fetch_unit_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic [31:0] squash_count;

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_instr,
    output imem_address, if_instr, if_pc, if_valid, fetch_count, squash_count
  );

  modport master (
    output stall, redirect_valid, redirect_target, imem_instr,
    input  imem_address, if_instr, if_pc, if_valid, fetch_count, squash_count
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs each returned memory word with
// its PC and valid flag, and handles stall hold, redirect squash and PC wrap.
module fetch_unit
  import scu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.slave  bus
);

  localparam int            AW      = addr_width(IMEM_DEPTH);
  localparam logic [AW-1:0] PC_INIT = RESET_PC[AW-1:0];

  logic [AW-1:0] pc_q,          pc_d;
  logic [AW-1:0] slot_pc_q,     slot_pc_d;
  logic          slot_valid_q,  slot_valid_d;
  logic          held_q,        held_d;
  logic [31:0]   held_instr_q,  held_instr_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic [31:0]   squash_count_q, squash_count_d;

  logic          unused_target_bits;
  logic [31:0]   slot_instr;

  // Target bits above the memory index are intentionally discarded.
  if (AW < 32) begin : g_unused_target
    assign unused_target_bits = ^bus.redirect_target[31:AW];
  end else begin : g_no_unused_target
    assign unused_target_bits = 1'b0;
  end

  always_comb begin
    pc_d           = pc_q;
    slot_pc_d      = slot_pc_q;
    slot_valid_d   = slot_valid_q;
    held_d         = held_q;
    held_instr_d   = held_instr_q;
    fetch_count_d  = fetch_count_q;
    squash_count_d = squash_count_q;

    if (bus.redirect_valid) begin
      pc_d         = bus.redirect_target[AW-1:0];
      slot_valid_d = 1'b0;
      held_d       = 1'b0;
      if (slot_valid_q) begin
        squash_count_d = squash_count_q + 32'd1;
      end
    end else if (bus.stall) begin
      // The memory keeps reading every edge and would move on to pc; latch
      // the word of the stalled slot on the first stall edge so it holds.
      if (!held_q) begin
        held_d       = 1'b1;
        held_instr_d = bus.imem_instr;
      end
    end else begin
      slot_pc_d    = pc_q;
      pc_d         = pc_q + 1'b1;
      slot_valid_d = 1'b1;
      held_d       = 1'b0;
      if (slot_valid_q) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= PC_INIT;
      slot_pc_q      <= '0;
      slot_valid_q   <= 1'b0;
      held_q         <= 1'b0;
      held_instr_q   <= NOP_INSTR;
      fetch_count_q  <= '0;
      squash_count_q <= '0;
    end else begin
      pc_q           <= pc_d;
      slot_pc_q      <= slot_pc_d;
      slot_valid_q   <= slot_valid_d;
      held_q         <= held_d;
      held_instr_q   <= held_instr_d;
      fetch_count_q  <= fetch_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign slot_instr       = held_q ? held_instr_q : bus.imem_instr;
  assign bus.imem_address = 32'(pc_q);
  assign bus.if_pc        = 32'(slot_pc_q);
  assign bus.if_valid     = slot_valid_q;
  assign bus.if_instr     = slot_valid_q ? slot_instr : NOP_INSTR;
  assign bus.fetch_count  = fetch_count_q;
  assign bus.squash_count = squash_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered-read instruction memory
// preloaded so that instr[k] = k+1.
module tb_fetch_unit;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  logic [31:0] mem [0:255];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (256)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: one cycle of registered read latency, no enable.
  always @(posedge clock) begin
    bus.imem_instr <= mem[bus.imem_address[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc,
                          input logic [31:0] instr, input logic valid);
    chk({tag, ".if_pc"},    bus.if_pc,           pc);
    chk({tag, ".if_instr"}, bus.if_instr,        instr);
    chk({tag, ".if_valid"}, {31'd0, bus.if_valid}, {31'd0, valid});
    $display("slot %s: if_pc=%0d if_instr=%h if_valid=%0b fetch=%0d squash=%0d",
             tag, bus.if_pc, bus.if_instr, bus.if_valid, bus.fetch_count, bus.squash_count);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < 256; k++) mem[k] = 32'(k + 1);
    bus.imem_instr      = 32'h0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    reset_n             = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst.imem_address", bus.imem_address, 32'd0);
    chk("rst.fetch_count",  bus.fetch_count,  32'd0);
    chk("rst.squash_count", bus.squash_count, 32'd0);
    chk_slot("rst", 32'd0, 32'd0, 1'b0);
    reset_n = 1'b1;

    // Free run from RESET_PC
    step(); chk_slot("run0", 32'd0, 32'd1, 1'b1);
    chk("run0.imem_address", bus.imem_address, 32'd1);
    chk("run0.fetch_count",  bus.fetch_count,  32'd0);
    step(); chk_slot("run1", 32'd1, 32'd2, 1'b1);
    step(); chk_slot("run2", 32'd2, 32'd3, 1'b1);
    chk("run2.fetch_count", bus.fetch_count, 32'd2);

    // Stall 3 cycles at if_pc=2
    bus.stall = 1'b1;
    step(); chk_slot("stall0", 32'd2, 32'd3, 1'b1);
    step(); chk_slot("stall1", 32'd2, 32'd3, 1'b1);
    step(); chk_slot("stall2", 32'd2, 32'd3, 1'b1);
    chk("stall2.fetch_count",  bus.fetch_count,  32'd2);
    chk("stall2.imem_address", bus.imem_address, 32'd3);
    bus.stall = 1'b0;
    step(); chk_slot("resume3", 32'd3, 32'd4, 1'b1);
    chk("resume3.fetch_count", bus.fetch_count, 32'd3);
    step(); chk_slot("resume4", 32'd4, 32'd5, 1'b1);
    step(); chk_slot("run5", 32'd5, 32'd6, 1'b1);
    chk("run5.fetch_count", bus.fetch_count, 32'd5);

    // Redirect to 30 while if_pc=5
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'd30;
    step(); chk_slot("redir_bubble", bus.if_pc, 32'd0, 1'b0);
    chk("redir.squash_count", bus.squash_count, 32'd1);
    chk("redir.imem_address", bus.imem_address, 32'd30);
    bus.redirect_valid = 1'b0;
    step(); chk_slot("redir30", 32'd30, 32'd31, 1'b1);
    chk("redir30.fetch_count", bus.fetch_count, 32'd5);
    step(); chk_slot("redir31", 32'd31, 32'd32, 1'b1);
    chk("redir31.fetch_count", bus.fetch_count, 32'd6);

    // Redirect and stall together: redirect wins
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'd8;
    bus.stall           = 1'b1;
    step(); chk("rs.if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rs.squash_count", bus.squash_count, 32'd2);
    chk("rs.fetch_count",  bus.fetch_count,  32'd6);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    step(); chk_slot("rs8", 32'd8, 32'd9, 1'b1);

    // Back-to-back redirects; upper target bits ignored (0xABCD01FE -> 254)
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'd100;
    step(); chk("b2b0.if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("b2b0.squash_count", bus.squash_count, 32'd3);
    bus.redirect_target = 32'hABCD_01FE;
    step(); chk("b2b1.if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("b2b1.squash_count", bus.squash_count, 32'd3);
    chk("b2b1.imem_address", bus.imem_address, 32'd254);
    bus.redirect_valid = 1'b0;

    // Wrap-around 254, 255, 0, 1
    step(); chk_slot("wrap254", 32'd254, 32'd255, 1'b1);
    step(); chk_slot("wrap255", 32'd255, 32'd256, 1'b1);
    chk("wrap255.imem_address", bus.imem_address, 32'd0);
    step(); chk_slot("wrap0", 32'd0, 32'd1, 1'b1);
    step(); chk_slot("wrap1", 32'd1, 32'd2, 1'b1);
    chk("wrap1.fetch_count", bus.fetch_count, 32'd9);

    // Asynchronous reset mid-stream
    #2 reset_n = 1'b0;
    #1;
    chk("arst.imem_address", bus.imem_address, 32'd0);
    chk("arst.fetch_count",  bus.fetch_count,  32'd0);
    chk("arst.squash_count", bus.squash_count, 32'd0);
    chk_slot("arst", 32'd0, 32'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step(); chk_slot("rerun0", 32'd0, 32'd1, 1'b1);
    chk("rerun0.fetch_count", bus.fetch_count, 32'd0);
    step(); chk_slot("rerun1", 32'd1, 32'd2, 1'b1);
    chk("rerun1.fetch_count", bus.fetch_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
